// File: rtl/wb_unit_pkg.sv
// Shared types and constants for the write-back sequencer (wb_unit) and its load queue.
package wb_unit_pkg;

  localparam int unsigned REGFILE_SIZE = 32;
  localparam int unsigned RADR_W       = $clog2(REGFILE_SIZE);
  localparam logic [RADR_W-1:0] ZERO_REG = '0;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } ld_type_e;

  typedef struct packed {
    logic [RADR_W-1:0] wadr;
    logic [2:0]        ltype;
    logic [1:0]        ofs;
  } ldq_entry_t;

endpackage

// File: rtl/wb_ldq.sv
// Outstanding-load FIFO: in-order push on issue, pop on memory response, plus
// combinational hazard compare of decode source registers against all pending entries.
module wb_ldq
  import wb_unit_pkg::*;
#(
  parameter int unsigned LDQ_DEPTH = 4,
  parameter int unsigned LDQ_AW    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  ldq_entry_t        i_push_entry,
  input  logic              i_pop,
  input  logic [RADR_W-1:0] i_chk1,
  input  logic [RADR_W-1:0] i_chk2,
  output ldq_entry_t        o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_hazard
);

  ldq_entry_t        r_mem [LDQ_DEPTH];
  logic [LDQ_AW-1:0] r_wptr;
  logic [LDQ_AW-1:0] r_rptr;
  logic [LDQ_AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_hazard;

  assign w_full  = (r_count == (LDQ_AW+1)'(LDQ_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [LDQ_AW-1:0] w_dist;
    w_hazard = 1'b0;
    w_dist   = '0;
    for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
      w_dist = LDQ_AW'(i) - r_rptr;
      if (({1'b0, w_dist} < r_count) && (r_mem[i].wadr != ZERO_REG) &&
          ((r_mem[i].wadr == i_chk1) || (r_mem[i].wadr == i_chk2)))
        w_hazard = 1'b1;
    end
  end

  assign o_head   = r_mem[r_rptr];
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_hazard = w_hazard;

endmodule

// File: rtl/wb_unit.sv
// Register-file write-back sequencer merging ALU results and in-order load responses.
// Optional WB_FWD_EN adds Fwd1/Fwd2/FwdData bypass outputs for same-cycle write/read.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int unsigned LDQ_DEPTH = 4,
  parameter int unsigned LDQ_AW    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AluValid,
  input  logic [4:0]  AluWadr,
  input  logic [31:0] AluData,
  output logic        AluReady,
  input  logic        LdIssue,
  input  logic [4:0]  LdWadr,
  input  logic [2:0]  LdType,
  input  logic [1:0]  LdOfs,
  output logic        LdFull,
  input  logic        MemRvalid,
  input  logic [31:0] MemRdata,
  input  logic [4:0]  ChkAdr1,
  input  logic [4:0]  ChkAdr2,
  output logic        Hazard,
  output logic        Wen,
  output logic [4:0]  Wadr,
  output logic [31:0] Wdata
`ifdef WB_FWD_EN
  ,
  output logic        Fwd1,
  output logic        Fwd2,
  output logic [31:0] FwdData
`endif
);

  function automatic logic [31:0] ld_extract(input logic [31:0] word,
                                             input logic [2:0]  lt,
                                             input logic [1:0]  ofs);
    logic [7:0]  b;
    logic [15:0] h;
    case (ofs)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = ofs[1] ? word[15:0] : word[31:16];
    case (lt)
      LT_LH:   return {{16{h[15]}}, h};
      LT_LHU:  return {16'b0, h};
      LT_LB:   return {{24{b[7]}}, b};
      LT_LBU:  return {24'b0, b};
      default: return word;
    endcase
  endfunction

  ldq_entry_t w_push_entry;
  ldq_entry_t w_head;
  logic       w_ldq_full;
  logic       w_ldq_empty;
  logic       w_hazard;
  logic       w_ld_valid;

  logic        r_hold_v;
  logic [4:0]  r_hold_adr;
  logic [31:0] r_hold_data;
  logic        r_wen;
  logic [4:0]  r_wadr;
  logic [31:0] r_wdata;

  logic        w_sel_v;
  logic [4:0]  w_sel_adr;
  logic [31:0] w_sel_data;
  logic        w_hold_load;
  logic        w_hold_drain;

  assign w_push_entry = '{wadr: LdWadr, ltype: LdType, ofs: LdOfs};
  assign w_ld_valid   = MemRvalid && !w_ldq_empty;

  wb_ldq #(
    .LDQ_DEPTH(LDQ_DEPTH),
    .LDQ_AW   (LDQ_AW)
  ) u_ldq (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_push      (LdIssue),
    .i_push_entry(w_push_entry),
    .i_pop       (MemRvalid),
    .i_chk1      (ChkAdr1),
    .i_chk2      (ChkAdr2),
    .o_head      (w_head),
    .o_full      (w_ldq_full),
    .o_empty     (w_ldq_empty),
    .o_hazard    (w_hazard)
  );

  // Load response wins; a colliding ALU offer parks in the hold register.
  always_comb begin
    w_sel_v      = 1'b0;
    w_sel_adr    = '0;
    w_sel_data   = '0;
    w_hold_load  = 1'b0;
    w_hold_drain = 1'b0;
    if (w_ld_valid) begin
      w_sel_v     = 1'b1;
      w_sel_adr   = w_head.wadr;
      w_sel_data  = ld_extract(MemRdata, w_head.ltype, w_head.ofs);
      w_hold_load = AluValid && !r_hold_v;
    end else if (r_hold_v) begin
      w_sel_v      = 1'b1;
      w_sel_adr    = r_hold_adr;
      w_sel_data   = r_hold_data;
      w_hold_drain = 1'b1;
    end else if (AluValid) begin
      w_sel_v    = 1'b1;
      w_sel_adr  = AluWadr;
      w_sel_data = AluData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wen       <= 1'b0;
      r_wadr      <= '0;
      r_wdata     <= '0;
      r_hold_v    <= 1'b0;
      r_hold_adr  <= '0;
      r_hold_data <= '0;
    end else begin
      r_wen <= w_sel_v && (w_sel_adr != ZERO_REG);
      if (w_sel_v && (w_sel_adr != ZERO_REG)) begin
        r_wadr  <= w_sel_adr;
        r_wdata <= w_sel_data;
      end
      if (w_hold_load) begin
        r_hold_v    <= 1'b1;
        r_hold_adr  <= AluWadr;
        r_hold_data <= AluData;
      end else if (w_hold_drain) begin
        r_hold_v <= 1'b0;
      end
    end
  end

  assign AluReady = !r_hold_v;
  assign LdFull   = w_ldq_full;
  assign Hazard   = w_hazard;
  assign Wen      = r_wen;
  assign Wadr     = r_wadr;
  assign Wdata    = r_wdata;

`ifdef WB_FWD_EN
  assign Fwd1    = r_wen && (r_wadr != ZERO_REG) && (r_wadr == ChkAdr1);
  assign Fwd2    = r_wen && (r_wadr != ZERO_REG) && (r_wadr == ChkAdr2);
  assign FwdData = r_wdata;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed self-checking bench for wb_unit: inputs change at negedge, outputs checked 1ns later.
module tb_wb_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AluValid;
  logic [4:0]  AluWadr;
  logic [31:0] AluData;
  logic        AluReady;
  logic        LdIssue;
  logic [4:0]  LdWadr;
  logic [2:0]  LdType;
  logic [1:0]  LdOfs;
  logic        LdFull;
  logic        MemRvalid;
  logic [31:0] MemRdata;
  logic [4:0]  ChkAdr1;
  logic [4:0]  ChkAdr2;
  logic        Hazard;
  logic        Wen;
  logic [4:0]  Wadr;
  logic [31:0] Wdata;
`ifdef WB_FWD_EN
  logic        Fwd1;
  logic        Fwd2;
  logic [31:0] FwdData;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  wb_unit #(
    .LDQ_DEPTH(4),
    .LDQ_AW   (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .AluValid (AluValid),
    .AluWadr  (AluWadr),
    .AluData  (AluData),
    .AluReady (AluReady),
    .LdIssue  (LdIssue),
    .LdWadr   (LdWadr),
    .LdType   (LdType),
    .LdOfs    (LdOfs),
    .LdFull   (LdFull),
    .MemRvalid(MemRvalid),
    .MemRdata (MemRdata),
    .ChkAdr1  (ChkAdr1),
    .ChkAdr2  (ChkAdr2),
    .Hazard   (Hazard),
    .Wen      (Wen),
    .Wadr     (Wadr),
    .Wdata    (Wdata)
`ifdef WB_FWD_EN
    ,
    .Fwd1     (Fwd1),
    .Fwd2     (Fwd2),
    .FwdData  (FwdData)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [4:0] adr, input logic [2:0] lt,
                         input logic [1:0] ofs, input logic [31:0] word,
                         input logic [31:0] exp);
    @(negedge CLK); LdIssue = 1'b1; LdWadr = adr; LdType = lt; LdOfs = ofs;
    @(negedge CLK); LdIssue = 1'b0; MemRvalid = 1'b1; MemRdata = word;
    @(negedge CLK); MemRvalid = 1'b0; #1;
    chk({tag, "_wen"}, Wen, 1'b1);
    chk({tag, "_wadr"}, Wadr, adr);
    chk({tag, "_wdata"}, Wdata, exp);
  endtask

  initial begin
    RST = 1'b1; AluValid = 1'b0; AluWadr = '0; AluData = '0;
    LdIssue = 1'b0; LdWadr = '0; LdType = '0; LdOfs = '0;
    MemRvalid = 1'b0; MemRdata = '0; ChkAdr1 = '0; ChkAdr2 = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0; #1;
    chk("rst_wen", Wen, 1'b0);
    chk("rst_wadr", Wadr, 5'd0);
    chk("rst_wdata", Wdata, 32'h0);
    chk("rst_ldfull", LdFull, 1'b0);
    chk("rst_hazard", Hazard, 1'b0);
    chk("rst_aluready", AluReady, 1'b1);

    // ALU only
    @(negedge CLK); AluValid = 1'b1; AluWadr = 5'd8; AluData = 32'h12345678; #1;
    chk("alu_ready", AluReady, 1'b1);
    @(negedge CLK); AluValid = 1'b0; #1;
    chk("alu_wen", Wen, 1'b1);
    chk("alu_wadr", Wadr, 5'd8);
    chk("alu_wdata", Wdata, 32'h12345678);

    // Load extraction
    do_load("lb",  5'd9,  3'd3, 2'd1, 32'h00F30000, 32'hFFFFFFF3);
    do_load("lbu", 5'd9,  3'd4, 2'd1, 32'h00F30000, 32'h000000F3);
    do_load("lh",  5'd10, 3'd1, 2'd2, 32'h00008001, 32'hFFFF8001);
    do_load("lhu", 5'd11, 3'd2, 2'd0, 32'h80011234, 32'h00008001);
    do_load("lb3", 5'd12, 3'd3, 2'd3, 32'h12345680, 32'hFFFFFF80);
    do_load("lw",  5'd13, 3'd0, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lt7", 5'd14, 3'd7, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);

    // Collision: response and ALU in cycle N
    @(negedge CLK); LdIssue = 1'b1; LdWadr = 5'd3; LdType = 3'd0; LdOfs = 2'd0;
    @(negedge CLK); LdIssue = 1'b0; MemRvalid = 1'b1; MemRdata = 32'hAAAA0003;
    AluValid = 1'b1; AluWadr = 5'd4; AluData = 32'h00000044; #1;
    chk("col_ready_n", AluReady, 1'b1);
    @(negedge CLK); MemRvalid = 1'b0; AluData = 32'h00000055; #1;
    chk("col_ready_n1", AluReady, 1'b0);
    chk("col_wadr_n1", Wadr, 5'd3);
    chk("col_wdata_n1", Wdata, 32'hAAAA0003);
    @(negedge CLK); #1;
    chk("col_ready_n2", AluReady, 1'b1);
    chk("col_wen_n2", Wen, 1'b1);
    chk("col_wadr_n2", Wadr, 5'd4);
    chk("col_wdata_n2", Wdata, 32'h00000044);
    @(negedge CLK); AluValid = 1'b0; #1;
    chk("col_wen_n3", Wen, 1'b1);
    chk("col_wdata_n3", Wdata, 32'h00000055);
    @(negedge CLK); #1;
    chk("col_idle_wen", Wen, 1'b0);
    chk("col_idle_wdata", Wdata, 32'h00000055);

    // Full queue
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); LdIssue = 1'b1; LdWadr = 5'(10 + i); LdType = 3'd0; LdOfs = 2'd0;
    end
    @(negedge CLK); LdWadr = 5'd14; #1;
    chk("full_set", LdFull, 1'b1);
    @(negedge CLK); LdIssue = 1'b0; #1;
    chk("full_after_5th", LdFull, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); MemRvalid = (i < 4); MemRdata = 32'h100 + 32'(i); #1;
      if (i > 0) begin
        chk("full_drain_wen", Wen, 1'b1);
        chk("full_drain_wadr", Wadr, 5'(10 + i - 1));
        chk("full_drain_wdata", Wdata, 32'h100 + 32'(i - 1));
      end
    end
    @(negedge CLK); MemRvalid = 1'b1; MemRdata = 32'hBAD0BAD0; ChkAdr1 = 5'd14; #1;
    chk("drained_ldfull", LdFull, 1'b0);
    chk("drained_no_r14", Hazard, 1'b0);
    @(negedge CLK); MemRvalid = 1'b0; ChkAdr1 = '0; #1;
    chk("empty_resp_wen", Wen, 1'b0);

    // Hazard on r5 via ChkAdr1
    @(negedge CLK); LdIssue = 1'b1; LdWadr = 5'd5; LdType = 3'd0; ChkAdr1 = 5'd5; #1;
    chk("haz_issue_cycle", Hazard, 1'b0);
    @(negedge CLK); LdIssue = 1'b0; #1;
    chk("haz_pending1", Hazard, 1'b1);
    @(negedge CLK); #1;
    chk("haz_pending2", Hazard, 1'b1);
    @(negedge CLK); MemRvalid = 1'b1; MemRdata = 32'h00000005; #1;
    chk("haz_resp_cycle", Hazard, 1'b1);
    @(negedge CLK); MemRvalid = 1'b0; #1;
    chk("haz_cleared", Hazard, 1'b0);
    chk("haz_wadr", Wadr, 5'd5);
    ChkAdr1 = '0;

    // Hazard on r7 via ChkAdr2
    @(negedge CLK); LdIssue = 1'b1; LdWadr = 5'd7; ChkAdr2 = 5'd7;
    @(negedge CLK); LdIssue = 1'b0; #1;
    chk("haz2_pending", Hazard, 1'b1);
    @(negedge CLK); MemRvalid = 1'b1; MemRdata = 32'h7;
    @(negedge CLK); MemRvalid = 1'b0; ChkAdr2 = '0; #1;
    chk("haz2_cleared", Hazard, 1'b0);

    // Load to r0 never hazards and never writes
    @(negedge CLK); LdIssue = 1'b1; LdWadr = 5'd0; ChkAdr1 = 5'd0; ChkAdr2 = 5'd0;
    @(negedge CLK); LdIssue = 1'b0; #1;
    chk("r0_no_hazard", Hazard, 1'b0);
    @(negedge CLK); MemRvalid = 1'b1; MemRdata = 32'h12121212;
    @(negedge CLK); MemRvalid = 1'b0; #1;
    chk("r0_wen", Wen, 1'b0);

    // Reset mid-operation with two loads pending
    @(negedge CLK); LdIssue = 1'b1; LdWadr = 5'd20; ChkAdr1 = 5'd20;
    @(negedge CLK); LdWadr = 5'd21;
    @(negedge CLK); LdIssue = 1'b0; #1;
    chk("prerst_hazard", Hazard, 1'b1);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0; MemRvalid = 1'b1; MemRdata = 32'hFFFFFFFF; #1;
    chk("postrst_ldfull", LdFull, 1'b0);
    chk("postrst_hazard", Hazard, 1'b0);
    @(negedge CLK); MemRvalid = 1'b0; #1;
    chk("postrst_wen", Wen, 1'b0);
    chk("postrst_wdata", Wdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Register-file write-back sequencer; the producer of the write side (Wadr/Wdata/write-enable) that the decode-stage register file consumes.
- Merges single-cycle ALU results with variable-latency load responses from data memory.
- Performs MIPS big-endian load extraction/extension.
- Tracks outstanding loads so decode can detect load-use hazards.

Parameters:
- LDQ_DEPTH, 4: maximum outstanding loads; power of two, ≥2.
- LDQ_AW, 2: log2(LDQ_DEPTH); pointer width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- AluValid  in  1  ALU result offered this cycle.
- AluWadr  in  5  ALU destination register.
- AluData  in  32  ALU result.
- AluReady  out  1  ALU result accepted this cycle (combinational).
- LdIssue  in  1  load issued to memory this cycle.
- LdWadr  in  5  load destination register.
- LdType  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU; others behave as LW.
- LdOfs  in  2  address bits [1:0].
- LdFull  out  1  queue full; issuer must not assert LdIssue.
- MemRvalid  in  1  in-order memory response valid.
- MemRdata  in  32  raw memory word.
- ChkAdr1  in  5  decode source register 1.
- ChkAdr2  in  5  decode source register 2.
- Hazard  out  1  a pending load targets a nonzero ChkAdr1/ChkAdr2 (combinational).
- Wen  out  1  register-file write enable (registered).
- Wadr  out  5  write address (registered).
- Wdata  out  32  write data (registered).

Behaviour:
- Reset: Wen=0, Wadr=0, Wdata=0, queue empty, hold register empty, LdFull=0, Hazard=0, AluReady=1.
- Load queue: circular FIFO of {Wadr, Type, Ofs}; LDQ_AW-bit pointers plus an occupancy counter 0..LDQ_DEPTH.
  - Push on LdIssue; pop on MemRvalid.
  - Both in the same cycle: count unchanged.
  - Pointers wrap modulo LDQ_DEPTH.
  - LdFull = (count == LDQ_DEPTH).
  - LdIssue while full: ignored, no state change.
  - MemRvalid while empty: ignored, Wen=0.
- Load extraction (big-endian):
  - Byte select by LdOfs: 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Half select by LdOfs[1]: 0 -> [31:16], 1 -> [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Arbitration, evaluated each cycle:
  - Priority order: memory response, then hold register, then live ALU.
  - MemRvalid with a live ALU offer and empty hold: ALU result captured into the one-entry hold register; AluReady=1.
  - Hold full: AluReady=0.
  - Hold drains on the first cycle without MemRvalid; the live ALU offer is not accepted that cycle.
  - Accepted ALU result is written next cycle.
- Write output: the selected write appears on Wen/Wadr/Wdata one cycle after its source cycle.
  - Selected write address 0: Wen=0, but the entry is still consumed/popped.
  - No source: Wen=0; Wadr/Wdata hold their last values.
- Hazard: compare ChkAdr1/2 against every valid queue entry; address 0 never hazards.
  - An entry popped this cycle is still counted as pending this cycle.
- Reset mid-operation: queue and hold are flushed; responses arriving after reset are ignored while the queue is empty.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds outputs Fwd1, Fwd2 (1 bit) and FwdData (32 bit).
  - Fwd1 = Wen && Wadr != 0 && Wadr == ChkAdr1; Fwd2 likewise for ChkAdr2.
  - FwdData = Wdata.
  - Covers the same-cycle write/read on the register file.
- Undefined: these ports are absent; decode reads the register file directly.

Decomposition:
- Shared package/header: load type codes (LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU), REGFILE_SIZE, zero-register index.
- One sub-module: wb_ldq (the load-tracking FIFO with hazard compare).
- Extraction and arbitration stay in wb_unit.

Test Plan:
- ALU only: AluValid, Wadr 8, data 0x12345678 -> next cycle Wen=1, Wadr=8, Wdata=0x12345678, AluReady=1.
- LB: ofs 1, MemRdata 0x00F30000 -> Wdata 0xFFFFFFF3. Same stimulus as LBU -> 0x000000F3. LH ofs 2, word 0x00008001 -> 0xFFFF8001.
- Collision: MemRvalid (load to r3) and AluValid (r4) in cycle N; AluValid held in N+1 and N+2 -> writes r3 @N+1, r4 @N+2 (hold drains), live r4 offer accepted @N+2 and written @N+3; AluReady=1 @N, 0 @N+1, 1 @N+2.
- Full: issue 4 loads with no responses -> LdFull=1; a 5th LdIssue is ignored; 4 responses return the original destinations in order, count back to 0.
- Hazard: pending load to r5 with ChkAdr1=5 -> Hazard=1 until the response cycle inclusive. ChkAdr2=0 with a load to r0 pending -> Hazard=0, and Wen=0 on its response.
- Reset with 2 loads pending, then MemRvalid -> Wen=0, LdFull=0, Hazard=0.
